// File: rtl/calc_core_fx.sv
// calc_core_fx: fixed-point keypad calculator core.
// Decodes debounced key codes into operand entry, a chaining arithmetic FSM
// (add/sub/mul single cycle, restoring divider over 2*WIDTH cycles) and a
// bank of MEM_SLOTS memory registers.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   button, is_pressed_next  key code and debounced key-held level
//   operand_f/operand_s first operand (or result) and second operand, scaled by SCALE
//   negative, toggle    pending sign of the entry, shift layer active
//   state               FSM state (0..6), busy = divider running, error = in ERROR
//   mem_slot            selected memory slot
module calc_core_fx #(
    parameter int WIDTH          = 32,
    parameter int FRAC_DIGITS    = 2,
    parameter int SCALE          = 100,
    parameter int MAX_INT_DIGITS = 7,
    parameter int MEM_SLOTS      = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [3:0]                   button,
    input  logic                         is_pressed_next,
    output logic signed [WIDTH-1:0]      operand_f,
    output logic signed [WIDTH-1:0]      operand_s,
    output logic                         negative,
    output logic                         toggle,
    output logic [2:0]                   state,
    output logic                         busy,
    output logic                         error,
    output logic [$clog2(MEM_SLOTS)-1:0] mem_slot
);

    localparam logic [2:0] ST_INITIAL   = 3'd0;
    localparam logic [2:0] ST_OPERAND_F = 3'd1;
    localparam logic [2:0] ST_OPERATION = 3'd2;
    localparam logic [2:0] ST_OPERAND_S = 3'd3;
    localparam logic [2:0] ST_COMPUTE   = 3'd4;
    localparam logic [2:0] ST_RESULT    = 3'd5;
    localparam logic [2:0] ST_ERROR     = 3'd6;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int SLOT_W = $clog2(MEM_SLOTS);
    localparam int CNT_W  = $clog2(2 * WIDTH);
    localparam int ICNT_W = $clog2(MAX_INT_DIGITS + 2);
    localparam int FCNT_W = $clog2(FRAC_DIGITS + 2);

    localparam logic [CNT_W-1:0]          CNT_LAST  = CNT_W'(2 * WIDTH - 1);
    localparam logic [ICNT_W-1:0]         MAX_INT   = ICNT_W'(MAX_INT_DIGITS);
    localparam logic [FCNT_W-1:0]         MAX_FRAC  = FCNT_W'(FRAC_DIGITS);
    localparam logic [WIDTH-1:0]          TEN       = WIDTH'(10);
    localparam logic [WIDTH-1:0]          SCALE_W   = WIDTH'(SCALE);
    localparam logic [WIDTH-1:0]          FRAC_W0   = WIDTH'(SCALE / 10);
    localparam logic [2*WIDTH-1:0]        SCALE_2U  = (2 * WIDTH)'(SCALE);
    localparam logic signed [2*WIDTH-1:0] SCALE_2S  = (2 * WIDTH)'(SCALE);

    logic                    press_prev;
    logic [1:0]              op;
    logic [ICNT_W-1:0]       int_cnt;
    logic [FCNT_W-1:0]       frac_cnt;
    logic                    point;
    logic                    recalled;
    logic [WIDTH-1:0]        frac_w;
    logic signed [WIDTH-1:0] mem [MEM_SLOTS];

    logic [2*WIDTH-1:0]      div_q;
    logic [WIDTH-1:0]        div_rem;
    logic [WIDTH-1:0]        div_den;
    logic                    div_neg;
    logic [CNT_W-1:0]        div_cnt;
    logic [2:0]              div_next_state;
    logic [1:0]              div_next_op;

    // Key decode
    logic       key_event, live;
    logic       k_clear, k_shift, k_shifted, k_digit, k_op, k_eq;
    logic       k_point, k_neg, k_store, k_recall, k_mclr, k_minc;
    logic [1:0] k_opcode;

    // Operand datapath
    logic                    act_s;
    logic signed [WIDTH-1:0] act_val, f_commit, s_commit, slot_val;
    logic [WIDTH-1:0]        digit_scaled, int_next, frac_next, slot_mag;
    logic [WIDTH-1:0]        mag_f, mag_s;
    logic [2*WIDTH-1:0]      dividend;

    // Single-cycle arithmetic
    logic [WIDTH:0]          sum_ext, diff_ext;
    logic [2*WIDTH-1:0]      prod_u;
    logic signed [2*WIDTH-1:0] prod_q;
    logic                    mul_ovf;
    logic [WIDTH-1:0]        calc_val;
    logic                    calc_ovf;
    logic                    do_calc;
    logic [2:0]              calc_state;
    logic [1:0]              calc_next_op;

    // Divider step
    logic [WIDTH:0]          rem_sh;
    logic                    rem_ge;
    logic [WIDTH-1:0]        rem_sub, next_rem;
    logic [2*WIDTH-1:0]      next_q;
    logic                    div_fits;
    logic [WIDTH-1:0]        div_res;

    always_comb begin
        key_event = is_pressed_next & ~press_prev;
        live      = key_event && state != ST_ERROR && state != ST_COMPUTE;
        k_clear   = key_event && button == 4'hF;
        k_shift   = live && button == 4'hD;
        k_shifted = live && toggle && button != 4'hD && button != 4'hF;
        k_digit   = live && !toggle && button <= 4'd9;
        k_eq      = live && !toggle && button == 4'hE;
        k_op      = live && ((!toggle && (button == 4'hA || button == 4'hB || button == 4'hC))
                          || (toggle && button == 4'hA));
        k_point   = live && toggle && button == 4'hB;
        k_neg     = live && toggle && button == 4'hC;
        k_store   = live && toggle && button == 4'h1;
        k_recall  = live && toggle && button == 4'h2;
        k_mclr    = live && toggle && button == 4'h3;
        k_minc    = live && toggle && button == 4'h4;
        k_opcode  = OP_ADD;
        if (toggle) k_opcode = OP_DIV;
        else if (button == 4'hB) k_opcode = OP_SUB;
        else if (button == 4'hC) k_opcode = OP_MUL;
    end

    always_comb begin
        act_s        = (state == ST_OPERATION) || (state == ST_OPERAND_S);
        act_val      = act_s ? operand_s : operand_f;
        digit_scaled = WIDTH'(button) * SCALE_W;
        int_next     = act_val * TEN + digit_scaled;
        frac_next    = act_val + WIDTH'(button) * frac_w;
        // Entries are magnitudes; the pending sign lands only on the operand being committed.
        f_commit     = (negative && (state == ST_OPERAND_F || state == ST_RESULT)) ? -operand_f : operand_f;
        s_commit     = (negative && state == ST_OPERAND_S) ? -operand_s : operand_s;
        slot_val     = mem[mem_slot];
        slot_mag     = slot_val[WIDTH-1] ? -slot_val : slot_val;
        mag_f        = f_commit[WIDTH-1] ? -f_commit : f_commit;
        mag_s        = s_commit[WIDTH-1] ? -s_commit : s_commit;
        dividend     = {{WIDTH{1'b0}}, mag_f} * SCALE_2U;
    end

    always_comb begin
        sum_ext  = {f_commit[WIDTH-1], f_commit} + {s_commit[WIDTH-1], s_commit};
        diff_ext = {f_commit[WIDTH-1], f_commit} - {s_commit[WIDTH-1], s_commit};
        prod_u   = {{WIDTH{f_commit[WIDTH-1]}}, f_commit} * {{WIDTH{s_commit[WIDTH-1]}}, s_commit};
        prod_q   = $signed(prod_u) / SCALE_2S;
        mul_ovf  = !((&prod_q[2*WIDTH-1:WIDTH-1]) || !(|prod_q[2*WIDTH-1:WIDTH-1]));
        calc_val = '0;
        calc_ovf = 1'b0;
        case (op)
            OP_ADD: begin calc_val = sum_ext[WIDTH-1:0];  calc_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1]; end
            OP_SUB: begin calc_val = diff_ext[WIDTH-1:0]; calc_ovf = diff_ext[WIDTH] ^ diff_ext[WIDTH-1]; end
            OP_MUL: begin calc_val = prod_q[WIDTH-1:0];   calc_ovf = mul_ovf; end
            default: ;
        endcase
        do_calc      = (k_op && state == ST_OPERAND_S)
                    || (k_eq && (state == ST_OPERAND_S || state == ST_RESULT));
        calc_state   = k_op ? ST_OPERATION : ST_RESULT;
        calc_next_op = k_op ? k_opcode : op;
    end

    always_comb begin
        rem_sh   = {div_rem, div_q[2*WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, div_den};
        rem_sub  = rem_sh[WIDTH-1:0] - div_den;
        next_rem = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
        next_q   = {div_q[2*WIDTH-2:0], rem_ge};
        // A negative quotient may reach 2^(WIDTH-1); a positive one may not.
        div_fits = !(|next_q[2*WIDTH-1:WIDTH])
                && (!next_q[WIDTH-1] || (div_neg && !(|next_q[WIDTH-2:0])));
        div_res  = div_neg ? -next_q[WIDTH-1:0] : next_q[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            press_prev <= 1'b0;
            operand_f  <= '0;
            operand_s  <= '0;
            negative   <= 1'b0;
            toggle     <= 1'b0;
            state      <= ST_INITIAL;
            busy       <= 1'b0;
            error      <= 1'b0;
            mem_slot   <= '0;
            op         <= OP_ADD;
            int_cnt    <= '0;
            frac_cnt   <= '0;
            point      <= 1'b0;
            recalled   <= 1'b0;
            frac_w     <= FRAC_W0;
            div_q      <= '0;
            div_rem    <= '0;
            div_den    <= '0;
            div_neg    <= 1'b0;
            div_cnt    <= '0;
            div_next_state <= ST_INITIAL;
            div_next_op    <= OP_ADD;
            for (int unsigned i = 0; i < MEM_SLOTS; i++) mem[SLOT_W'(i)] <= '0;
        end else begin
            press_prev <= is_pressed_next;
            if (k_clear) begin
                operand_f <= '0;
                operand_s <= '0;
                negative  <= 1'b0;
                toggle    <= 1'b0;
                state     <= ST_INITIAL;
                busy      <= 1'b0;
                error     <= 1'b0;
                op        <= OP_ADD;
                int_cnt   <= '0;
                frac_cnt  <= '0;
                point     <= 1'b0;
                recalled  <= 1'b0;
                frac_w    <= FRAC_W0;
                div_cnt   <= '0;
            end else if (state == ST_COMPUTE) begin
                div_q   <= next_q;
                div_rem <= next_rem;
                div_cnt <= div_cnt + CNT_W'(1);
                if (div_cnt == CNT_LAST) begin
                    busy <= 1'b0;
                    if (div_fits) begin
                        operand_f <= div_res;
                        state     <= div_next_state;
                        op        <= div_next_op;
                    end else begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                    end
                end
            end else begin
                if (k_shift)   toggle <= ~toggle;
                if (k_shifted) toggle <= 1'b0;

                if (k_digit) begin
                    case (state)
                        ST_INITIAL, ST_RESULT, ST_OPERATION: begin
                            if (state == ST_OPERATION) begin
                                operand_s <= digit_scaled;
                                state     <= ST_OPERAND_S;
                            end else begin
                                operand_f <= digit_scaled;
                                state     <= ST_OPERAND_F;
                            end
                            int_cnt  <= ICNT_W'(1);
                            frac_cnt <= '0;
                            point    <= 1'b0;
                            recalled <= 1'b0;
                            frac_w   <= FRAC_W0;
                        end
                        ST_OPERAND_F, ST_OPERAND_S: begin
                            if (!recalled) begin
                                if (!point) begin
                                    if (int_cnt < MAX_INT) begin
                                        if (act_s) operand_s <= int_next;
                                        else       operand_f <= int_next;
                                        int_cnt <= int_cnt + ICNT_W'(1);
                                    end
                                end else if (frac_cnt < MAX_FRAC) begin
                                    if (act_s) operand_s <= frac_next;
                                    else       operand_f <= frac_next;
                                    frac_w   <= frac_w / TEN;
                                    frac_cnt <= frac_cnt + FCNT_W'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end

                if (k_op && (state == ST_OPERAND_F || state == ST_RESULT)) begin
                    operand_f <= f_commit;
                    negative  <= 1'b0;
                    op        <= k_opcode;
                    state     <= ST_OPERATION;
                    recalled  <= 1'b0;
                    point     <= 1'b0;
                end
                if (k_op && state == ST_OPERATION) op <= k_opcode;

                if (do_calc) begin
                    operand_f <= f_commit;
                    operand_s <= s_commit;
                    negative  <= 1'b0;
                    recalled  <= 1'b0;
                    point     <= 1'b0;
                    int_cnt   <= '0;
                    frac_cnt  <= '0;
                    if (op == OP_DIV) begin
                        if (s_commit == '0) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end else begin
                            state   <= ST_COMPUTE;
                            busy    <= 1'b1;
                            div_q   <= dividend;
                            div_rem <= '0;
                            div_den <= mag_s;
                            div_neg <= f_commit[WIDTH-1] ^ s_commit[WIDTH-1];
                            div_cnt <= '0;
                            div_next_state <= calc_state;
                            div_next_op    <= calc_next_op;
                        end
                    end else if (calc_ovf) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                    end else begin
                        operand_f <= calc_val;
                        op        <= calc_next_op;
                        state     <= calc_state;
                    end
                end

                if (k_point && (state == ST_OPERAND_F || state == ST_OPERAND_S)
                    && !point && !recalled) begin
                    point  <= 1'b1;
                    frac_w <= FRAC_W0;
                end
                if (k_neg)   negative <= ~negative;
                if (k_store) mem[mem_slot] <= act_val;
                if (k_mclr)  mem[mem_slot] <= '0;
                if (k_minc)  mem_slot <= mem_slot + SLOT_W'(1);
                if (k_recall) begin
                    if (act_s) begin
                        operand_s <= slot_mag;
                        state     <= ST_OPERAND_S;
                    end else begin
                        operand_f <= slot_mag;
                        state     <= ST_OPERAND_F;
                    end
                    negative <= slot_val[WIDTH-1];
                    recalled <= 1'b1;
                end
            end
        end
    end

endmodule
